// File: rtl/soale2_pkg.sv
// Shared constants for the soale2 registered ripple-carry adder.
package soale2_pkg;
    localparam int ADD_WIDTH = 8;
endpackage : soale2_pkg

// File: rtl/soale2_full_adder.sv
// One-bit full adder cell used to build the ripple-carry chain.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic prop;

    assign prop = x ^ y;
    assign sum  = prop ^ cin;
    assign cout = (x & y) | (cin & prop);
endmodule : full_adder

// File: rtl/soale2.sv
// Registered two's-complement adder: structural ripple-carry chain with
// a signed-overflow flag, both captured one cycle after the operands.
module soale2
    import soale2_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] s,
    output logic                    over
);
    // Signed overflow is exactly the disagreement between carry into and out of the MSB.
    function automatic logic ovf_f(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

    logic        [WIDTH:0]   carry;
    logic signed [WIDTH-1:0] s_d;
    logic signed [WIDTH-1:0] s_q;
    logic                    over_d;
    logic                    over_q;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .x   (a[i]),
            .y   (b[i]),
            .cin (carry[i]),
            .sum (s_d[i]),
            .cout(carry[i+1])
        );
    end

    assign over_d = ovf_f(carry[WIDTH-1], carry[WIDTH]);

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            over_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            over_q <= over_d;
        end
    end

    assign s    = s_q;
    assign over = over_q;
endmodule : soale2

// File: tb/tb_soale2.sv
// Self-checking bench for soale2: directed vector table, reset sequences
// and a randomized run against an integer-arithmetic reference model.
module tb_soale2;
    localparam int W = 8;

    logic                clk;
    logic                rst_n;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] s;
    logic                over;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_s;
        logic         exp_over;
    } vec_t;

    vec_t vecs[$];

    soale2 #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .s    (s),
        .over (over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] exp_s, input logic exp_o);
        n_checks++;
        if (s !== exp_s || over !== exp_o) begin
            n_fail++;
            $display("FAIL %s: got s=%02h over=%b, required s=%02h over=%b",
                     name, s, over, exp_s, exp_o);
        end
    endtask

    // Reference: true integer sum, wrapped to W bits; overflow when it leaves the signed range.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] ms, output logic mo);
        int sum;
        sum = int'($signed(ma)) + int'($signed(mb));
        ms  = sum[W-1:0];
        mo  = (sum > (2**(W-1)) - 1) || (sum < -(2**(W-1)));
    endtask

    task automatic apply(input logic [W-1:0] na, input logic [W-1:0] nb);
        @(negedge clk);
        a = na;
        b = nb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] prev_s;
        logic         prev_o;
        logic [W-1:0] ms;
        logic         mo;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_checks = 0;
        n_fail   = 0;

        vecs.push_back('{8'hB2, 8'hEF, 8'hA1, 1'b0});
        vecs.push_back('{8'h92, 8'h87, 8'h19, 1'b1});
        vecs.push_back('{8'h32, 8'h6F, 8'hA1, 1'b1});
        vecs.push_back('{8'h16, 8'h2F, 8'h45, 1'b0});
        vecs.push_back('{8'hDA, 8'hCF, 8'hA9, 1'b0});
        vecs.push_back('{8'hB2, 8'h47, 8'hF9, 1'b0});
        vecs.push_back('{8'h37, 8'h6C, 8'hA3, 1'b1});
        vecs.push_back('{8'h03, 8'hAF, 8'hB2, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 8'h80, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 8'h00, 1'b1});
        vecs.push_back('{8'h80, 8'h7F, 8'hFF, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 8'h00, 1'b0});
        vecs.push_back('{8'h80, 8'hFF, 8'h7F, 1'b1});
        vecs.push_back('{8'h7F, 8'h7F, 8'hFE, 1'b1});

        // Reset held with clocks running and overflowing operands present.
        rst_n = 1'b0;
        a     = 8'h7F;
        b     = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 8'h00, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_first_edge", 8'h80, 1'b1);

        foreach (vecs[i]) begin
            apply(vecs[i].va, vecs[i].vb);
            check($sformatf("vec%0d_%02h+%02h", i, vecs[i].va, vecs[i].vb),
                  vecs[i].exp_s, vecs[i].exp_over);
        end

        // Asynchronous reset mid-cycle discards the in-flight result immediately.
        apply(8'h37, 8'h6C);
        check("pre_async_reset", 8'hA3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("async_reset_held_over_edge", 8'h00, 1'b0);
        @(negedge clk);
        a     = 8'h92;
        b     = 8'h87;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_async_reset_capture", 8'h19, 1'b1);

        // Randomized run: outputs must hold between edges and match the model after each edge.
        prev_s = 8'h19;
        prev_o = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            @(negedge clk);
            a = ra;
            b = rb;
            #2;
            check("rand_hold_between_edges", prev_s, prev_o);
            @(posedge clk);
            #1;
            model(ra, rb, ms, mo);
            check($sformatf("rand%0d_%02h+%02h", k, ra, rb), ms, mo);
            prev_s = ms;
            prev_o = mo;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_soale2

// File: doc/soale2.md
SOALE2 -- requirements
Module: soale2

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (two's complement).
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port a, input, WIDTH bits: signed addend A.
REQ-006 The block SHALL have port b, input, WIDTH bits: signed addend B.
REQ-007 The block SHALL have port s, output, WIDTH bits: registered sum (a+b) mod 2^WIDTH.
REQ-008 The block SHALL have port over, output, 1 bit: registered signed-overflow flag for the same addition.
REQ-009 The port order SHALL be clk, rst_n, a, b, s, over.

Function
REQ-010 The sum SHALL be computed combinationally by a structural ripple-carry chain of WIDTH one-bit full adders, with carry-in 0.
REQ-011 The raw sum SHALL be the low WIDTH bits of a+b; the final carry-out is discarded and SHALL NOT be exported.
REQ-012 Overflow SHALL be 1 iff a[MSB]==b[MSB] and sum[MSB]!=a[MSB]; this is equivalent to carry into MSB XOR carry out of MSB.
REQ-013 Mixed-sign operands SHALL never flag overflow.
REQ-014 s and over SHALL be registered on each rising clk edge from the current a and b, giving a latency of 1 cycle.
REQ-015 The registers SHALL update every cycle, with no enable and no handshake.
REQ-016 Unsigned carry wrap, e.g. 0xDA+0xCF, SHALL produce the truncated sum with over=0 when signs agree with the result.
REQ-017 The result SHALL be correct at the boundaries: 0x7F+0x01 gives 0x80, over=1; 0x80+0x80 gives 0x00, over=1; 0x80+0x7F gives 0xFF, over=0; 0xFF+0x01 gives 0x00, over=0.
REQ-018 The block SHALL have no internal state other than the s and over registers.

Reset
REQ-019 When rst_n is low, s SHALL clear to 0 and over SHALL clear to 0 immediately, independent of clk.
REQ-020 Assertion of reset in mid-operation SHALL discard the in-flight result.
REQ-021 After rst_n deasserts, the first rising clk edge SHALL capture the current a and b.
REQ-022 Deassertion of reset is assumed synchronized externally.

Structure
REQ-023 The one-bit adder SHALL be a separate sub-module, full_adder (ports x, y, cin, sum, cout), instantiated WIDTH times via generate.
REQ-024 The default WIDTH value (8) SHALL be placed in a shared package as constant ADD_WIDTH; no typedefs are required.
REQ-025 The top level SHALL contain the carry chain, the overflow logic and the output register only.

Verification
REQ-026 Sequence: a=0xB2, b=0xEF, one clk -> s=0xA1, over=0; a=0x92, b=0x87 -> s=0x19, over=1.
REQ-027 Sequence: a=0x32, b=0x6F -> s=0xA1, over=1; a=0x16, b=0x2F -> s=0x45, over=0.
REQ-028 Sequence: a=0xDA, b=0xCF -> s=0xA9, over=0; a=0xB2, b=0x47 -> s=0xF9, over=0.
REQ-029 Sequence: a=0x37, b=0x6C -> s=0xA3, over=1; a=0x03, b=0xAF -> s=0xB2, over=0.
REQ-030 Reset: hold rst_n=0 with a=0x7F, b=0x01 and clocks running -> s=0x00, over=0; release rst_n and apply one edge -> s=0x80, over=1.
REQ-031 Latency: change a and b between edges -> s and over change only at the next rising edge, and match a random-vector reference model over at least 1000 cycles.
